// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, flush bubble insertion,
// optional two-entry skid buffer and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              in_fire;
  logic              out_fire;

  // Skid mode keeps in_ready purely registered; out_ready never reaches it.
  assign in_ready  = (SKID != 0) ? ~s_valid : (~m_valid | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid & out_ready;
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
    end else if (SKID == 0) begin
      if (in_fire) begin
        m_valid <= 1'b1;
        m_ctrl  <= in_ctrl;
        m_data  <= in_data;
      end else if (out_fire) begin
        m_valid <= 1'b0;
      end
    end else begin
      if (out_fire && s_valid) begin
        m_valid <= 1'b1;
        m_ctrl  <= s_ctrl;
        m_data  <= s_data;
        if (in_fire) begin
          s_ctrl <= in_ctrl;
          s_data <= in_data;
        end else begin
          s_valid <= 1'b0;
        end
      end else if (in_fire && (!m_valid || out_fire)) begin
        m_valid <= 1'b1;
        m_ctrl  <= in_ctrl;
        m_data  <= in_data;
      end else if (in_fire) begin
        s_valid <= 1'b1;
        s_ctrl  <= in_ctrl;
        s_data  <= in_data;
      end else if (out_fire) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Survives flush on purpose: it is a debug statistic, not pipeline state.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, non-skid and narrow-counter instances,
// with a FIFO scoreboard on the skid instance.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_in_ctrl, a_out_ctrl;
  logic [15:0] a_in_data, a_out_data, a_stall;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_ctrl, b_out_ctrl;
  logic [15:0] b_in_data, b_out_data, b_stall;

  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0]  c_in_ctrl, c_out_ctrl;
  logic [15:0] c_in_data, c_out_data;
  logic [3:0]  c_stall;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] q[$];

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(1), .CNT_W(16)) u_skid (
    .CLK(clk), .reset(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .stall_cnt(a_stall));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(0), .CNT_W(16)) u_noskid (
    .CLK(clk), .reset(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .stall_cnt(b_stall));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(1), .CNT_W(4)) u_sat (
    .CLK(clk), .reset(rst_n), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_ctrl(c_in_ctrl), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl),
    .out_data(c_out_data), .stall_cnt(c_stall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven at edge+1; handshakes are sampled at edge+3, then the edge is taken.
  task automatic cyc();
    logic [23:0] e;
    #2;
    if (a_flush) begin
      q.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_entry", {8'h0, a_out_ctrl, a_out_data}, {8'h0, e});
        end
      end
      if (a_in_valid && a_in_ready) q.push_back({a_in_ctrl, a_in_data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = 0; a_in_data = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = 0; b_in_data = 0;
    c_flush = 0; c_in_valid = 0; c_out_ready = 0; c_in_ctrl = 0; c_in_data = 0;
    #2;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_ctrl", 32'(a_out_ctrl), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_stall", 32'(a_stall), 32'd0);
    chk("rst_in_ready_skid", 32'(a_in_ready), 32'd1);
    chk("rst_in_ready_noskid", 32'(b_in_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming, 1 entry/cycle
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_ctrl = 8'h5A; a_in_data = 16'(i);
      if (i > 1) chk("stream_valid", 32'(a_out_valid), 32'd1);
      chk("stream_in_ready", 32'(a_in_ready), 32'd1);
      cyc();
      if (i == 1) chk("stream_latency", 32'(a_out_data), 32'd1);
    end
    a_in_valid = 0;
    cyc();
    chk("stream_drained", 32'(a_out_valid), 32'd0);
    chk("stream_stall", 32'(a_stall), 32'd0);

    // Back-pressure into the skid entry
    a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 8'h11; a_in_data = 16'd1;
    cyc();
    a_in_data = 16'd2;
    chk("bp_ready_before", 32'(a_in_ready), 32'd1);
    cyc();
    chk("bp_ready_fell", 32'(a_in_ready), 32'd0);
    a_in_data = 16'd3;
    cyc();
    cyc();
    chk("bp_ready_held", 32'(a_in_ready), 32'd0);
    chk("bp_head", 32'(a_out_data), 32'd1);
    chk("bp_stall", 32'(a_stall), 32'd3);
    a_out_ready = 1;
    cyc();
    chk("bp_ready_rise", 32'(a_in_ready), 32'd1);
    chk("bp_second", 32'(a_out_data), 32'd2);
    cyc();
    a_in_valid = 0;
    chk("bp_third", 32'(a_out_data), 32'd3);
    cyc();
    chk("bp_empty", 32'(a_out_valid), 32'd0);
    chk("bp_stall_final", 32'(a_stall), 32'd3);

    // Flush of a full stage with a concurrent input
    a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 8'h22; a_in_data = 16'd1;
    cyc();
    a_in_data = 16'd2;
    cyc();
    a_in_data = 16'd9; a_flush = 1;
    cyc();
    a_flush = 0; a_in_valid = 0;
    chk("flush_valid", 32'(a_out_valid), 32'd0);
    chk("flush_ctrl", 32'(a_out_ctrl), 32'd0);
    chk("flush_in_ready", 32'(a_in_ready), 32'd1);
    chk("flush_data_held", 32'(a_out_data), 32'd1);
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_no_ghost", 32'(a_out_valid), 32'd0);
    end
    chk("flush_stall", 32'(a_stall), 32'd5);

    // Non-skid: combinational ready and bubble-free replacement
    b_in_valid = 1; b_in_ctrl = 8'h33; b_in_data = 16'h41; b_out_ready = 1;
    cyc();
    b_out_ready = 0; b_in_data = 16'h42;
    #1;
    chk("noskid_ready_low", 32'(b_in_ready), 32'd0);
    cyc();
    chk("noskid_hold", 32'(b_out_data), 32'h41);
    b_out_ready = 1;
    #1;
    chk("noskid_ready_high", 32'(b_in_ready), 32'd1);
    cyc();
    chk("noskid_replace_valid", 32'(b_out_valid), 32'd1);
    chk("noskid_replace_data", 32'(b_out_data), 32'h42);
    b_in_valid = 0;
    cyc();
    chk("noskid_empty_valid", 32'(b_out_valid), 32'd0);
    chk("noskid_empty_ctrl", 32'(b_out_ctrl), 32'd0);

    // Narrow counter saturation
    c_in_valid = 1; c_in_ctrl = 8'h44; c_in_data = 16'h55; c_out_ready = 0;
    cyc();
    c_in_valid = 0;
    repeat (14) cyc();
    chk("sat_14", 32'(c_stall), 32'd14);
    repeat (6) cyc();
    chk("sat_15", 32'(c_stall), 32'd15);
    c_flush = 1;
    cyc();
    c_flush = 0;
    chk("sat_after_flush", 32'(c_stall), 32'd15);
    chk("sat_flush_valid", 32'(c_out_valid), 32'd0);

    // Asynchronous reset mid-stream
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_in_ctrl = 8'h66; a_in_data = 16'(16'h20 + i);
      cyc();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_out_valid), 32'd0);
    chk("arst_ctrl", 32'(a_out_ctrl), 32'd0);
    chk("arst_data", 32'(a_out_data), 32'd0);
    chk("arst_stall", 32'(a_stall), 32'd0);
    chk("arst_sat_stall", 32'(c_stall), 32'd0);
    q.delete();
    a_in_valid = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    a_in_valid = 1; a_in_ctrl = 8'h77; a_in_data = 16'h30;
    cyc();
    a_in_valid = 0;
    chk("arst_first_valid", 32'(a_out_valid), 32'd1);
    chk("arst_first_data", 32'(a_out_data), 32'h30);
    cyc();
    chk("sb_final_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
